// File: rtl/wb_trace_checker.sv
// wb_trace_checker: captures up to NUM_CH write-backs per cycle into an
// in-order commit buffer and compares them one per cycle against a golden
// trace stream (valid/ready). Reports sticky status, counters and a snapshot
// of the first mismatching entry.
module wb_trace_checker #(
    parameter int          NUM_CH      = 2,
    parameter int          DEPTH       = 8,
    parameter logic [31:0] END_PC      = 32'hbfc00100,
    parameter logic [31:0] SKIP_MASK   = 32'hfffffff8,
    parameter logic [31:0] SKIP_BASE   = 32'hbfc00380,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     wb_en,
    input  logic [32*NUM_CH-1:0]  wb_pc,
    input  logic [5*NUM_CH-1:0]   wb_rd,
    input  logic [32*NUM_CH-1:0]  wb_wdata,
    input  logic                  ref_valid,
    output logic                  ref_ready,
    input  logic [31:0]           ref_pc,
    input  logic [4:0]            ref_rd,
    input  logic [31:0]           ref_wdata,
    output logic                  err,
    output logic                  overflow,
    output logic                  done,
    output logic [15:0]           err_count,
    output logic [31:0]           cmp_count,
    output logic [31:0]           err_pc,
    output logic [4:0]            err_rd,
    output logic [31:0]           err_wdata,
    output logic [31:0]           err_ref_pc,
    output logic [4:0]            err_ref_rd,
    output logic [31:0]           err_ref_wdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Commit buffer storage; data needs no reset, validity lives in the pointers.
    logic [31:0] pc_mem_r  [DEPTH];
    logic [4:0]  rd_mem_r  [DEPTH];
    logic [31:0] wd_mem_r  [DEPTH];
    logic        chk_mem_r [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] count_s;
    logic             empty_s;
    logic             full_s;
    logic [CNT_W-1:0] free_s;

    logic [PTR_W-1:0] acc_s;
    logic [PTR_W-1:0] k_s;
    logic [IDX_W-1:0] addr_s [NUM_CH];
    logic             want_push_s;
    logic             push_s;
    logic             ovf_evt_s;

    logic             pop_s;
    logic [IDX_W-1:0] head_idx_s;
    logic [31:0]      head_pc_s;
    logic [4:0]       head_rd_s;
    logic [31:0]      head_wd_s;
    logic             head_chk_s;
    logic             is_end_s;
    logic             mis_s;

    logic             err_r;
    logic             overflow_r;
    logic             done_r;
    logic [15:0]      err_count_r;
    logic [31:0]      cmp_count_r;
    logic [31:0]      err_pc_r;
    logic [4:0]       err_rd_r;
    logic [31:0]      err_wdata_r;
    logic [31:0]      err_ref_pc_r;
    logic [4:0]       err_ref_rd_r;
    logic [31:0]      err_ref_wdata_r;

    // Occupancy: full when the wrap bits differ and the index bits match.
    always_comb begin
        count_s = wr_ptr_r - rd_ptr_r;
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                  (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    end

    assign ref_ready = (state_r == ST_RUN) && !empty_s;

    // Head-of-buffer compare: END_PC terminates, skip window and enable=0 entries are not checked.
    always_comb begin
        pop_s      = ref_valid && ref_ready;
        head_idx_s = rd_ptr_r[IDX_W-1:0];
        head_pc_s  = pc_mem_r[head_idx_s];
        head_rd_s  = rd_mem_r[head_idx_s];
        head_wd_s  = wd_mem_r[head_idx_s];
        head_chk_s = chk_mem_r[head_idx_s];
        is_end_s   = (ref_pc == END_PC);
        if (pop_s && !is_end_s && head_chk_s &&
            ((head_pc_s & SKIP_MASK) != SKIP_BASE)) begin
            mis_s = (head_pc_s != ref_pc) || (head_rd_s != ref_rd) ||
                    (head_wd_s != ref_wdata);
        end else begin
            mis_s = 1'b0;
        end
    end

    // Push group: compact enabled channels in ascending order; accept all or nothing.
    always_comb begin
        acc_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            addr_s[i] = wr_ptr_r[IDX_W-1:0] + acc_s[IDX_W-1:0];
            acc_s     = acc_s + PTR_W'(wb_en[i]);
        end
        k_s = acc_s;
        if (full_s) begin
            free_s = CNT_W'(pop_s);
        end else begin
            free_s = CNT_W'(DEPTH) - {1'b0, count_s} + CNT_W'(pop_s);
        end
        want_push_s = (state_r == ST_RUN) && (k_s != '0);
        if (want_push_s && ({1'b0, k_s} <= free_s)) begin
            push_s    = 1'b1;
            ovf_evt_s = 1'b0;
        end else begin
            push_s    = 1'b0;
            ovf_evt_s = want_push_s;
        end
    end

    // Next-state logic: HALT and DONE hold until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (pop_s && is_end_s) begin
                    state_nxt_s = ST_DONE;
                end else if (mis_s && STOP_ON_ERR) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            ST_DONE: state_nxt_s = ST_DONE;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Write accepted channels into the buffer, tagging each with the enable seen at this edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_s && wb_en[i]) begin
                pc_mem_r[addr_s[i]]  <= wb_pc[32*i +: 32];
                rd_mem_r[addr_s[i]]  <= wb_rd[5*i +: 5];
                wd_mem_r[addr_s[i]]  <= wb_wdata[32*i +: 32];
                chk_mem_r[addr_s[i]] <= enable;
            end
        end
    end

    // State, pointers, sticky flags, counters and first-mismatch snapshot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r         <= ST_RUN;
            wr_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            err_r           <= 1'b0;
            overflow_r      <= 1'b0;
            done_r          <= 1'b0;
            err_count_r     <= 16'd0;
            cmp_count_r     <= 32'd0;
            err_pc_r        <= 32'd0;
            err_rd_r        <= 5'd0;
            err_wdata_r     <= 32'd0;
            err_ref_pc_r    <= 32'd0;
            err_ref_rd_r    <= 5'd0;
            err_ref_wdata_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + k_s;
            end
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_ONE;
                cmp_count_r <= cmp_count_r + 32'd1;
                if (is_end_s) begin
                    done_r <= 1'b1;
                end
            end
            if (mis_s) begin
                err_r <= 1'b1;
                if (err_count_r != 16'hffff) begin
                    err_count_r <= err_count_r + 16'd1;
                end
                if (!err_r) begin
                    err_pc_r        <= head_pc_s;
                    err_rd_r        <= head_rd_s;
                    err_wdata_r     <= head_wd_s;
                    err_ref_pc_r    <= ref_pc;
                    err_ref_rd_r    <= ref_rd;
                    err_ref_wdata_r <= ref_wdata;
                end
            end
        end
    end

    assign err           = err_r;
    assign overflow      = overflow_r;
    assign done          = done_r;
    assign err_count     = err_count_r;
    assign cmp_count     = cmp_count_r;
    assign err_pc        = err_pc_r;
    assign err_rd        = err_rd_r;
    assign err_wdata     = err_wdata_r;
    assign err_ref_pc    = err_ref_pc_r;
    assign err_ref_rd    = err_ref_rd_r;
    assign err_ref_wdata = err_ref_wdata_r;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: instance a halts on error, instance b
// counts and continues. Both share stimulus.
module tb_wb_trace_checker;

    localparam logic [31:0] END_PC = 32'hbfc00100;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic [1:0]  wb_en;
    logic [63:0] wb_pc;
    logic [9:0]  wb_rd;
    logic [63:0] wb_wdata;
    logic        ref_valid;
    logic [31:0] ref_pc;
    logic [4:0]  ref_rd;
    logic [31:0] ref_wdata;

    logic        a_ready, a_err, a_ovf, a_done;
    logic [15:0] a_ecnt;
    logic [31:0] a_ccnt, a_epc, a_ewd, a_rpc, a_rwd;
    logic [4:0]  a_erd, a_rrd;
    logic        b_ready, b_err, b_ovf, b_done;
    logic [15:0] b_ecnt;
    logic [31:0] b_ccnt, b_epc, b_ewd, b_rpc, b_rwd;
    logic [4:0]  b_erd, b_rrd;

    int n_checks;
    int n_pass;

    wb_trace_checker #(.NUM_CH(2), .DEPTH(8), .STOP_ON_ERR(1'b1)) dut_a (
        .clk(clk), .resetn(resetn), .enable(enable), .wb_en(wb_en),
        .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .ref_valid(ref_valid), .ref_ready(a_ready),
        .ref_pc(ref_pc), .ref_rd(ref_rd), .ref_wdata(ref_wdata),
        .err(a_err), .overflow(a_ovf), .done(a_done),
        .err_count(a_ecnt), .cmp_count(a_ccnt),
        .err_pc(a_epc), .err_rd(a_erd), .err_wdata(a_ewd),
        .err_ref_pc(a_rpc), .err_ref_rd(a_rrd), .err_ref_wdata(a_rwd)
    );

    wb_trace_checker #(.NUM_CH(2), .DEPTH(8), .STOP_ON_ERR(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .enable(enable), .wb_en(wb_en),
        .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .ref_valid(ref_valid), .ref_ready(b_ready),
        .ref_pc(ref_pc), .ref_rd(ref_rd), .ref_wdata(ref_wdata),
        .err(b_err), .overflow(b_ovf), .done(b_done),
        .err_count(b_ecnt), .cmp_count(b_ccnt),
        .err_pc(b_epc), .err_rd(b_erd), .err_wdata(b_ewd),
        .err_ref_pc(b_rpc), .err_ref_rd(b_rrd), .err_ref_wdata(b_rwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
        wb_pc[32*ch +: 32]    = pc;
        wb_rd[5*ch +: 5]      = rd;
        wb_wdata[32*ch +: 32] = wd;
    endtask

    task automatic set_ref(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
        ref_pc    = pc;
        ref_rd    = rd;
        ref_wdata = wd;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        enable    = 1'b1;
        wb_en     = 2'b00;
        wb_pc     = 64'd0;
        wb_rd     = 10'd0;
        wb_wdata  = 64'd0;
        ref_valid = 1'b0;
        set_ref(32'd0, 5'd0, 32'd0);
        cyc();
        resetn = 1'b1;
    endtask

    function automatic logic [31:0] ent_pc(input int j);
        return 32'h8000_0000 + 32'(j * 4);
    endfunction
    function automatic logic [4:0] ent_rd(input int j);
        return 5'(j + 1);
    endfunction
    function automatic logic [31:0] ent_wd(input int j);
        return 32'(j * 3 + 7);
    endfunction

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        resetn    = 1'b0;
        enable    = 1'b0;
        wb_en     = 2'b00;
        wb_pc     = 64'd0;
        wb_rd     = 10'd0;
        wb_wdata  = 64'd0;
        ref_valid = 1'b0;
        set_ref(32'd0, 5'd0, 32'd0);
        #1;
        check_eq("rst_ready", {62'd0, a_ready, b_ready}, 64'd0);
        check_eq("rst_flags", {61'd0, a_err, a_ovf, a_done}, 64'd0);
        check_eq("rst_cmp", a_ccnt, 64'd0);

        // In-order pops, all matching
        do_reset();
        wb_en = 2'b11;
        set_ch(0, 32'hbfc00000, 5'd1, 32'd1);
        set_ch(1, 32'hbfc00004, 5'd2, 32'd2);
        cyc();
        check_eq("s1_ready", a_ready, 64'd1);
        check_eq("s1_cmp0", a_ccnt, 64'd0);
        wb_en = 2'b00;
        ref_valid = 1'b1;
        set_ref(32'hbfc00000, 5'd1, 32'd1);
        cyc();
        check_eq("s1_cmp1", a_ccnt, 64'd1);
        set_ref(32'hbfc00004, 5'd2, 32'd2);
        cyc();
        check_eq("s1_cmp2", {a_ccnt, b_ccnt}, {32'd2, 32'd2});
        check_eq("s1_err", {62'd0, a_err, b_err}, 64'd0);
        check_eq("s1_empty", a_ready, 64'd0);

        // Mismatches: a halts at the first, b counts all three
        do_reset();
        wb_en = 2'b11;
        set_ch(0, 32'hbfc00000, 5'd1, 32'd1);
        set_ch(1, 32'hbfc00004, 5'd2, 32'd2);
        cyc();
        set_ch(0, 32'hbfc00008, 5'd3, 32'd4);
        set_ch(1, 32'hbfc0000c, 5'd4, 32'd5);
        cyc();
        wb_en = 2'b00;
        ref_valid = 1'b1;
        set_ref(32'hbfc00000, 5'd1, 32'd1);
        cyc();
        check_eq("s2_noerr", {62'd0, a_err, b_err}, 64'd0);
        set_ref(32'hbfc00004, 5'd2, 32'd3);
        cyc();
        check_eq("s2_a_err", a_err, 64'd1);
        check_eq("s2_a_ecnt", a_ecnt, 64'd1);
        check_eq("s2_a_ewd", a_ewd, 64'd2);
        check_eq("s2_a_rwd", a_rwd, 64'd3);
        check_eq("s2_a_epc", a_epc, 64'hbfc00004);
        check_eq("s2_a_halt", a_ready, 64'd0);
        set_ref(32'hbfc00008, 5'd3, 32'd7);
        cyc();
        set_ref(32'hbfc0000c, 5'd5, 32'd5);
        cyc();
        check_eq("s2_a_cmp", a_ccnt, 64'd2);
        check_eq("s2_a_ecnt2", a_ecnt, 64'd1);
        check_eq("s2_b_ecnt", b_ecnt, 64'd3);
        check_eq("s2_b_cmp", b_ccnt, 64'd4);
        check_eq("s2_b_snap", {b_ewd, b_rwd}, {32'd2, 32'd3});
        check_eq("s2_b_rrd", b_rrd, 64'd2);
        ref_valid = 1'b0;
        // Asynchronous reset between edges
        resetn = 1'b0;
        #1;
        check_eq("s2_arst_err", {62'd0, a_err, b_err}, 64'd0);
        check_eq("s2_arst_cnt", {a_ecnt, b_ccnt}, 64'd0);
        check_eq("s2_arst_snap", b_ewd, 64'd0);

        // Fill, pop+push at full, then a dropped group
        do_reset();
        for (int g = 0; g < 4; g++) begin
            wb_en = 2'b11;
            set_ch(0, ent_pc(2*g), ent_rd(2*g), ent_wd(2*g));
            set_ch(1, ent_pc(2*g+1), ent_rd(2*g+1), ent_wd(2*g+1));
            cyc();
        end
        check_eq("s3_ovf_full", a_ovf, 64'd0);
        wb_en = 2'b01;
        set_ch(0, ent_pc(8), ent_rd(8), ent_wd(8));
        ref_valid = 1'b1;
        set_ref(ent_pc(0), ent_rd(0), ent_wd(0));
        cyc();
        check_eq("s3_ovf_poppush", a_ovf, 64'd0);
        ref_valid = 1'b0;
        wb_en = 2'b11;
        set_ch(0, ent_pc(9), ent_rd(9), ent_wd(9));
        set_ch(1, ent_pc(10), ent_rd(10), ent_wd(10));
        cyc();
        check_eq("s3_ovf", {62'd0, a_ovf, b_ovf}, 64'd3);
        wb_en = 2'b00;
        ref_valid = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            set_ref(ent_pc(j), ent_rd(j), ent_wd(j));
            cyc();
        end
        check_eq("s3_cmp", a_ccnt, 64'd9);
        check_eq("s3_err", {62'd0, a_err, b_err}, 64'd0);
        check_eq("s3_drained", a_ready, 64'd0);
        ref_valid = 1'b0;

        // Skip window and enable=0 entries are consumed unchecked
        do_reset();
        wb_en = 2'b01;
        enable = 1'b1;
        set_ch(0, 32'hbfc00384, 5'd3, 32'd5);
        cyc();
        enable = 1'b0;
        set_ch(0, 32'hbfc00010, 5'd4, 32'd6);
        cyc();
        enable = 1'b1;
        set_ch(0, 32'hbfc00014, 5'd5, 32'd7);
        cyc();
        wb_en = 2'b00;
        ref_valid = 1'b1;
        set_ref(32'hbfc00384, 5'd3, 32'd99);
        cyc();
        set_ref(32'hbfc00010, 5'd4, 32'd77);
        cyc();
        check_eq("s4_cmp", a_ccnt, 64'd2);
        check_eq("s4_err", {62'd0, a_err, b_err}, 64'd0);
        set_ref(32'hbfc00014, 5'd5, 32'd8);
        cyc();
        check_eq("s4_ctrl_err", {62'd0, a_err, b_err}, 64'd3);
        check_eq("s4_ctrl_rwd", a_rwd, 64'd8);
        ref_valid = 1'b0;

        // END_PC terminates checking; later pushes and pops ignored
        do_reset();
        wb_en = 2'b11;
        set_ch(0, 32'hbfc00000, 5'd1, 32'd1);
        set_ch(1, 32'hbfc00004, 5'd2, 32'd2);
        cyc();
        wb_en = 2'b00;
        ref_valid = 1'b1;
        set_ref(END_PC, 5'd0, 32'd0);
        cyc();
        check_eq("s5_done", {62'd0, a_done, b_done}, 64'd3);
        check_eq("s5_cmp", a_ccnt, 64'd1);
        check_eq("s5_err", a_err, 64'd0);
        check_eq("s5_ready", a_ready, 64'd0);
        wb_en = 2'b11;
        set_ref(32'hbfc00004, 5'd2, 32'd2);
        cyc();
        cyc();
        check_eq("s5_ignored", {a_ccnt, b_ccnt}, {32'd1, 32'd1});
        check_eq("s5_ready2", {62'd0, a_ready, b_ready}, 64'd0);
        resetn = 1'b0;
        #1;
        check_eq("s5_arst_done", {62'd0, a_done, b_done}, 64'd0);
        check_eq("s5_arst_cmp", a_ccnt, 64'd0);
        wb_en = 2'b00;
        ref_valid = 1'b0;
        #3;
        resetn = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
